memory_access_stage: RTL and testbench



---
 rtl/memory_access_stage_pkg.sv | 75 +++++++
 rtl/memory_access_stage_load_data_extender.sv | 35 +++
 rtl/memory_access_stage.sv | 178 +++++++++++++++++
 tb/tb_memory_access_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared pipeline definitions: integer and register-index types, ALU and memory operator
// enums, bus payload struct, and the lane/extension helpers used by the MEM stage.
package memory_access_stage_pkg;

  localparam int unsigned INT_W     = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned BE_W      = 4;

  typedef logic [INT_W-1:0]     int_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [BE_W-1:0]      byte_enable_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_operator_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LBU      = 4'd2,
    LH       = 4'd3,
    LHU      = 4'd4,
    LW       = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_operator_t;

  localparam byte_enable_t BE_WORD    = 4'b1111;
  localparam byte_enable_t BE_HALF_LO = 4'b0011;
  localparam byte_enable_t BE_HALF_HI = 4'b1100;
  localparam byte_enable_t BE_BYTE0   = 4'b0001;

  typedef struct packed {
    logic         write;
    int_t         address;
    byte_enable_t byte_enable;
    int_t         write_data;
  } bus_req_t;

  function automatic logic is_load(mem_operator_t op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

  function automatic logic is_store(mem_operator_t op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic logic is_half(mem_operator_t op);
    return op inside {LH, LHU, SH};
  endfunction

  function automatic logic is_word(mem_operator_t op);
    return op inside {LW, SW};
  endfunction

  function automatic logic is_misaligned(mem_operator_t op, logic [1:0] lane);
    return (is_half(op) && lane[0]) || (is_word(op) && (lane != 2'b00));
  endfunction

  // Sub-size address bits are ignored: halfwords look only at lane[1], words at nothing.
  function automatic byte_enable_t lane_enable(mem_operator_t op, logic [1:0] lane);
    if (is_word(op)) return BE_WORD;
    if (is_half(op)) return lane[1] ? BE_HALF_HI : BE_HALF_LO;
    return BE_BYTE0 << lane;
  endfunction

  function automatic int_t replicate_store(mem_operator_t op, int_t data);
    if (is_word(op)) return data;
    if (is_half(op)) return {2{data[15:0]}};
    return {4{data[7:0]}};
  endfunction

endpackage

// File: rtl/memory_access_stage_load_data_extender.sv
// Selects the addressed byte/halfword of a little-endian read word and sign- or zero-extends it.
module load_data_extender
  import memory_access_stage_pkg::*;
(
  input  int_t          readWord,
  input  logic [1:0]    addr,
  input  mem_operator_t op,
  output int_t          extended
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = readWord[7:0];
    case (addr)
      2'd0:    byte_sel = readWord[7:0];
      2'd1:    byte_sel = readWord[15:8];
      2'd2:    byte_sel = readWord[23:16];
      default: byte_sel = readWord[31:24];
    endcase
    half_sel = addr[1] ? readWord[31:16] : readWord[15:0];

    extended = '0;
    case (op)
      LB:      extended = {{24{byte_sel[7]}}, byte_sel};
      LBU:     extended = {24'd0, byte_sel};
      LH:      extended = {{16{half_sel[15]}}, half_sel};
      LHU:     extended = {16'd0, half_sel};
      LW:      extended = readWord;
      default: extended = '0;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: passes ALU results through or runs one valid/ready bus transaction per load/store.
// Define MEMORY_ACCESS_ALIGNMENT_TRAP_EN to trap misaligned accesses instead of truncating the address.
module memory_access_stage
  import memory_access_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 exValid,
  output logic                 exReady,
  input  logic [INT_W-1:0]     exResult,
  input  logic [INT_W-1:0]     exStoreData,
  input  logic [3:0]           exMemOp,
  input  logic [REG_IDX_W-1:0] exDestReg,
  input  logic                 exWriteEnable,
  output logic                 busRequest,
  output logic                 busWrite,
  output logic [INT_W-1:0]     busAddress,
  output logic [BE_W-1:0]      busByteEnable,
  output logic [INT_W-1:0]     busWriteData,
  input  logic                 busReady,
  input  logic [INT_W-1:0]     busReadData,
  output logic                 wbValid,
  output logic [REG_IDX_W-1:0] wbDestReg,
  output logic                 wbWriteEnable,
  output logic [INT_W-1:0]     wbData,
  output logic                 addressError,
  output logic [INT_W-1:0]     badAddress
);

  typedef enum logic {IDLE, WAIT_BUS} state_t;

  state_t        state, state_next;
  bus_req_t      bus_q, bus_next;
  logic          bus_request_q, bus_request_next;
  mem_operator_t op_q, op_next;
  logic [1:0]    lane_q, lane_next;
  logic          we_q, we_next;
  logic          wb_valid_q, wb_valid_next;
  logic          wb_we_q, wb_we_next;
  reg_idx_t      wb_dest_q, wb_dest_next;
  int_t          wb_data_q, wb_data_next;
  mem_operator_t ex_op;
  int_t          load_value;

`ifdef MEMORY_ACCESS_ALIGNMENT_TRAP_EN
  logic addr_err_q, addr_err_next;
  int_t bad_addr_q, bad_addr_next;
`endif

  assign ex_op = mem_operator_t'(exMemOp);

  load_data_extender u_load_data_extender (
    .readWord (busReadData),
    .addr     (lane_q),
    .op       (op_q),
    .extended (load_value)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and next-output logic
  always_comb begin
    state_next       = state;
    bus_next         = bus_q;
    bus_request_next = bus_request_q;
    op_next          = op_q;
    lane_next        = lane_q;
    we_next          = we_q;
    wb_valid_next    = 1'b0;
    wb_we_next       = 1'b0;
    wb_dest_next     = wb_dest_q;
    wb_data_next     = wb_data_q;
`ifdef MEMORY_ACCESS_ALIGNMENT_TRAP_EN
    addr_err_next    = 1'b0;
    bad_addr_next    = bad_addr_q;
`endif

    case (state)
      IDLE: begin
        if (exValid) begin
          wb_dest_next = exDestReg;
          if (!is_load(ex_op) && !is_store(ex_op)) begin
            wb_valid_next = 1'b1;
            wb_we_next    = exWriteEnable;
            wb_data_next  = exResult;
          end
`ifdef MEMORY_ACCESS_ALIGNMENT_TRAP_EN
          else if (is_misaligned(ex_op, exResult[1:0])) begin
            wb_valid_next = 1'b1;
            addr_err_next = 1'b1;
            bad_addr_next = exResult;
          end
`endif
          else begin
            state_next           = WAIT_BUS;
            bus_request_next     = 1'b1;
            bus_next.write       = is_store(ex_op);
            bus_next.address     = {exResult[INT_W-1:2], 2'b00};
            bus_next.byte_enable = lane_enable(ex_op, exResult[1:0]);
            bus_next.write_data  = replicate_store(ex_op, exStoreData);
            op_next              = ex_op;
            lane_next            = exResult[1:0];
            we_next              = exWriteEnable;
          end
        end
      end
      WAIT_BUS: begin
        if (busReady) begin
          state_next       = IDLE;
          bus_request_next = 1'b0;
          wb_valid_next    = 1'b1;
          wb_we_next       = is_load(op_q) && we_q;
          if (is_load(op_q)) wb_data_next = load_value;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output and transaction registers
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_q         <= '0;
      bus_request_q <= 1'b0;
      op_q          <= MEM_NONE;
      lane_q        <= 2'b00;
      we_q          <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_dest_q     <= '0;
      wb_data_q     <= '0;
    end else begin
      bus_q         <= bus_next;
      bus_request_q <= bus_request_next;
      op_q          <= op_next;
      lane_q        <= lane_next;
      we_q          <= we_next;
      wb_valid_q    <= wb_valid_next;
      wb_we_q       <= wb_we_next;
      wb_dest_q     <= wb_dest_next;
      wb_data_q     <= wb_data_next;
    end
  end

`ifdef MEMORY_ACCESS_ALIGNMENT_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_err_q <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      addr_err_q <= addr_err_next;
      bad_addr_q <= bad_addr_next;
    end
  end

  assign addressError = addr_err_q;
  assign badAddress   = bad_addr_q;
`else
  assign addressError = 1'b0;
  assign badAddress   = '0;
`endif

  assign exReady       = (state == IDLE);
  assign busRequest    = bus_request_q;
  assign busWrite      = bus_q.write;
  assign busAddress    = bus_q.address;
  assign busByteEnable = bus_q.byte_enable;
  assign busWriteData  = bus_q.write_data;
  assign wbValid       = wb_valid_q;
  assign wbDestReg     = wb_dest_q;
  assign wbWriteEnable = wb_we_q;
  assign wbData        = wb_data_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the stage.
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        exValid;
  logic        exReady;
  logic [31:0] exResult;
  logic [31:0] exStoreData;
  logic [3:0]  exMemOp;
  logic [4:0]  exDestReg;
  logic        exWriteEnable;
  logic        busRequest;
  logic        busWrite;
  logic [31:0] busAddress;
  logic [3:0]  busByteEnable;
  logic [31:0] busWriteData;
  logic        busReady;
  logic [31:0] busReadData;
  logic        wbValid;
  logic [4:0]  wbDestReg;
  logic        wbWriteEnable;
  logic [31:0] wbData;
  logic        addressError;
  logic [31:0] badAddress;

  always #5 clock = ~clock;

  memory_access_stage dut (
    .clock         (clock),
    .reset         (reset),
    .exValid       (exValid),
    .exReady       (exReady),
    .exResult      (exResult),
    .exStoreData   (exStoreData),
    .exMemOp       (exMemOp),
    .exDestReg     (exDestReg),
    .exWriteEnable (exWriteEnable),
    .busRequest    (busRequest),
    .busWrite      (busWrite),
    .busAddress    (busAddress),
    .busByteEnable (busByteEnable),
    .busWriteData  (busWriteData),
    .busReady      (busReady),
    .busReadData   (busReadData),
    .wbValid       (wbValid),
    .wbDestReg     (wbDestReg),
    .wbWriteEnable (wbWriteEnable),
    .wbData        (wbData),
    .addressError  (addressError),
    .badAddress    (badAddress)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Model: one outstanding transaction at most, plus the expected output values.
  bit          m_busy = 1'b0;
  logic [3:0]  p_op;
  logic [1:0]  p_lane;
  logic [4:0]  p_dest;
  logic        p_we;
  logic        e_ready, e_req, e_write;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  logic        e_wbv, e_wbwe, e_wbcmp, e_err;
  logic [4:0]  e_dest;
  logic [31:0] e_data, e_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned size_of(input logic [3:0] op);
    case (mem_operator_t'(op))
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit model_is_load(input logic [3:0] op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  task automatic model_update();
    int unsigned sz;
    logic [1:0]  off;
    logic [31:0] raw, val;
    if (reset) begin
      m_busy = 1'b0; e_ready = 1'b1; e_req = 1'b0; e_wbv = 1'b0; e_wbwe = 1'b0;
      e_wbcmp = 1'b0; e_err = 1'b0; e_bad = 32'd0;
      return;
    end
    e_wbv = 1'b0; e_wbwe = 1'b0; e_wbcmp = 1'b0; e_err = 1'b0;
    if (m_busy) begin
      if (busReady) begin
        m_busy = 1'b0; e_ready = 1'b1; e_req = 1'b0; e_wbv = 1'b1;
        if (model_is_load(p_op)) begin
          sz  = size_of(p_op);
          off = p_lane & 2'(~(sz - 1));
          raw = busReadData >> (8 * off);
          if (sz == 1) begin
            val = raw & 32'hFF;
            if (p_op == LB && val[7]) val = val | 32'hFFFF_FF00;
          end else if (sz == 2) begin
            val = raw & 32'hFFFF;
            if (p_op == LH && val[15]) val = val | 32'hFFFF_0000;
          end else begin
            val = raw;
          end
          e_data = val; e_wbcmp = 1'b1; e_wbwe = p_we; e_dest = p_dest;
        end
      end
    end else if (exValid) begin
      sz = size_of(exMemOp);
      if (sz == 0) begin
        e_wbv = 1'b1; e_wbwe = exWriteEnable; e_wbcmp = 1'b1;
        e_data = exResult; e_dest = exDestReg;
      end
`ifdef MEMORY_ACCESS_ALIGNMENT_TRAP_EN
      else if ((exResult % sz) != 0) begin
        e_wbv = 1'b1; e_err = 1'b1; e_bad = exResult;
      end
`endif
      else begin
        off     = exResult[1:0] & 2'(~(sz - 1));
        m_busy  = 1'b1; e_ready = 1'b0; e_req = 1'b1;
        e_write = !model_is_load(exMemOp);
        e_addr  = exResult & 32'hFFFF_FFFC;
        e_be    = 4'(((1 << sz) - 1) << off);
        if (sz == 1)      e_wd = {24'd0, exStoreData[7:0]} * 32'h0101_0101;
        else if (sz == 2) e_wd = {16'd0, exStoreData[15:0]} * 32'h0001_0001;
        else              e_wd = exStoreData;
        p_op = exMemOp; p_lane = exResult[1:0]; p_dest = exDestReg; p_we = exWriteEnable;
      end
    end
  endtask

  // The single per-cycle compare of DUT outputs against the model.
  task automatic compare();
    check("exReady", 32'(exReady), 32'(e_ready));
    check("busRequest", 32'(busRequest), 32'(e_req));
    check("wbValid", 32'(wbValid), 32'(e_wbv));
    check("wbWriteEnable", 32'(wbWriteEnable), 32'(e_wbwe));
    check("addressError", 32'(addressError), 32'(e_err));
    if (e_req) begin
      check("busWrite", 32'(busWrite), 32'(e_write));
      check("busAddress", busAddress, e_addr);
      check("busByteEnable", 32'(busByteEnable), 32'(e_be));
      if (e_write) check("busWriteData", busWriteData, e_wd);
    end
    if (e_wbcmp) begin
      check("wbData", wbData, e_data);
      check("wbDestReg", 32'(wbDestReg), 32'(e_dest));
    end
`ifdef MEMORY_ACCESS_ALIGNMENT_TRAP_EN
    if (e_err) check("badAddress", badAddress, e_bad);
`else
    check("badAddress_tied", badAddress, 32'd0);
`endif
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare();
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] res,
                       input logic [31:0] sd, input logic [4:0] dest, input bit we,
                       input bit rdy, input logic [31:0] rd);
    exValid = v; exMemOp = op; exResult = res; exStoreData = sd;
    exDestReg = dest; exWriteEnable = we; busReady = rdy; busReadData = rd;
  endtask

  initial begin
    int low_cnt;
    int once_cnt;
    reset = 1'b1;
    drive(0, MEM_NONE, 0, 0, 0, 0, 0, 0);
    cycle();
    check("lit_reset_ready", 32'(exReady), 32'd1);
    check("lit_reset_busreq", 32'(busRequest), 32'd0);
    reset = 1'b0;

    // Back-to-back pass-through
    drive(1, MEM_NONE, 32'h1234_5678, 0, 5, 1, 0, 0);
    cycle();
    check("lit_none_valid", 32'(wbValid), 32'd1);
    check("lit_none_data", wbData, 32'h1234_5678);
    check("lit_none_dest", 32'(wbDestReg), 32'd5);
    drive(1, MEM_NONE, 32'h0000_AAAA, 0, 6, 1, 0, 0);
    cycle();
    check("lit_none2_data", wbData, 32'h0000_AAAA);
    drive(1, MEM_NONE, 32'h5555_FFFF, 0, 7, 0, 0, 0);
    cycle();
    check("lit_none3_data", wbData, 32'h5555_FFFF);
    check("lit_none3_we", 32'(wbWriteEnable), 32'd0);

    // LB / LBU from lane 3; busReady during the acceptance cycle is ignored
    drive(1, LB, 32'h1000_0003, 0, 3, 1, 1, 32'h80FF_FF00);
    cycle();
    check("lit_lb_addr", busAddress, 32'h1000_0000);
    check("lit_lb_be", 32'(busByteEnable), 32'b1000);
    check("lit_lb_wbvalid_early", 32'(wbValid), 32'd0);
    drive(0, MEM_NONE, 0, 0, 0, 0, 1, 32'h80FF_FF00);
    cycle();
    check("lit_lb_data", wbData, 32'hFFFF_FF80);
    check("lit_lb_busreq_drop", 32'(busRequest), 32'd0);
    drive(1, LBU, 32'h1000_0003, 0, 3, 1, 0, 32'h80FF_FF00);
    cycle();
    drive(0, MEM_NONE, 0, 0, 0, 0, 1, 32'h80FF_FF00);
    cycle();
    check("lit_lbu_data", wbData, 32'h0000_0080);

    // SH upper half with three wait cycles
    low_cnt = 0;
    drive(1, SH, 32'h2000_0002, 32'hABCD_BEEF, 9, 1, 0, 0);
    cycle();
    check("lit_sh_be", 32'(busByteEnable), 32'b1100);
    if (!exReady) low_cnt++;
    for (int i = 0; i < 3; i++) begin
      drive(0, MEM_NONE, 0, 0, 0, 0, 0, 0);
      cycle();
      check("lit_sh_wd_held", busWriteData, 32'hBEEF_BEEF);
      if (!exReady) low_cnt++;
    end
    drive(0, MEM_NONE, 0, 0, 0, 0, 1, 0);
    cycle();
    check("lit_sh_ready_low", 32'(low_cnt), 32'd4);
    check("lit_sh_wbvalid", 32'(wbValid), 32'd1);
    check("lit_sh_wbwe", 32'(wbWriteEnable), 32'd0);

    // Misaligned word
    drive(1, LW, 32'h0000_0006, 0, 2, 1, 0, 0);
    cycle();
`ifdef MEMORY_ACCESS_ALIGNMENT_TRAP_EN
    check("lit_lw_trap_busreq", 32'(busRequest), 32'd0);
    check("lit_lw_trap_err", 32'(addressError), 32'd1);
    check("lit_lw_trap_bad", badAddress, 32'h0000_0006);
    drive(0, MEM_NONE, 0, 0, 0, 0, 0, 0);
    cycle();
`else
    check("lit_lw_trunc_addr", busAddress, 32'h0000_0004);
    check("lit_lw_trunc_be", 32'(busByteEnable), 32'b1111);
    drive(0, MEM_NONE, 0, 0, 0, 0, 1, 32'h1357_9BDF);
    cycle();
    check("lit_lw_trunc_data", wbData, 32'h1357_9BDF);
`endif

    // Reset while waiting on the bus
    drive(1, SW, 32'h0000_0040, 32'h1111_2222, 0, 0, 0, 0);
    cycle();
    check("lit_rst_busreq_before", 32'(busRequest), 32'd1);
    reset = 1'b1;
    drive(0, MEM_NONE, 0, 0, 0, 0, 0, 0);
    cycle();
    check("lit_rst_busreq", 32'(busRequest), 32'd0);
    check("lit_rst_ready", 32'(exReady), 32'd1);
    check("lit_rst_wbvalid", 32'(wbValid), 32'd0);
    reset = 1'b0;

    // exValid held through WAIT_BUS is accepted exactly once
    once_cnt = 0;
    drive(1, LW, 32'h0000_0080, 0, 1, 1, 0, 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, MEM_NONE, 32'hCAFE_0001, 0, 4, 1, 0, 0);
      cycle();
      if (wbValid && wbData == 32'hCAFE_0001) once_cnt++;
    end
    drive(1, MEM_NONE, 32'hCAFE_0001, 0, 4, 1, 1, 0);
    cycle();
    if (wbValid && wbData == 32'hCAFE_0001) once_cnt++;
    drive(1, MEM_NONE, 32'hCAFE_0001, 0, 4, 1, 0, 0);
    cycle();
    if (wbValid && wbData == 32'hCAFE_0001) once_cnt++;
    for (int i = 0; i < 2; i++) begin
      drive(0, MEM_NONE, 0, 0, 0, 0, 0, 0);
      cycle();
      if (wbValid && wbData == 32'hCAFE_0001) once_cnt++;
    end
    check("lit_held_once", 32'(once_cnt), 32'd1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 8)), $urandom, $urandom,
            5'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), $urandom);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
